// File: rtl/bram_run_scheduler_if.sv
// Host-side BRAM0 access port of the run scheduler: request/grant handshake
// plus the read-valid strobe that tells the host when BRAM0 q is valid.
interface bram_run_scheduler_if #(
    parameter int AWIDTH = 8,
    parameter int DWIDTH = 32
);
    logic              host_req_i;
    logic              host_we_i;
    logic [AWIDTH-1:0] host_addr_i;
    logic [DWIDTH-1:0] host_wdata_i;
    logic              host_gnt_o;
    logic              host_rvalid_o;

    // Host register block side
    modport master (
        output host_req_i, host_we_i, host_addr_i, host_wdata_i,
        input  host_gnt_o, host_rvalid_o
    );

    // Scheduler side
    modport slave (
        input  host_req_i, host_we_i, host_addr_i, host_wdata_i,
        output host_gnt_o, host_rvalid_o
    );
endinterface

// File: rtl/bram_run_scheduler.sv
// BRAM0 run scheduler: owns the single BRAM0 port, lets the host preload it
// while idle, launches the accessor on a legal start command, waits for the
// accessor's done (or a timeout) and hands the port back to the host.
module bram_run_scheduler #(
    parameter int CNT_BIT  = 31,
    parameter int AWIDTH   = 8,
    parameter int DWIDTH   = 32,
    parameter int MEM_SIZE = 256,
    parameter int TO_SLACK = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    // host command / status
    input  logic               cmd_start_i,
    input  logic [CNT_BIT-1:0] cmd_count_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    // host BRAM0 access port
    bram_run_scheduler_if.slave host,
    // accessor
    output logic               acc_start_o,
    output logic [CNT_BIT-1:0] acc_count_o,
    input  logic               acc_done_i,
    input  logic [AWIDTH-1:0]  acc_addr_i,
    input  logic               acc_ce_i,
    // BRAM0 port
    output logic [AWIDTH-1:0]  bram_addr_o,
    output logic               bram_ce_o,
    output logic               bram_we_o,
    output logic [DWIDTH-1:0]  bram_d_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [CNT_BIT-1:0] MAX_CNT = CNT_BIT'(MEM_SIZE);
    localparam logic [CNT_BIT:0]   SLACK_W = (CNT_BIT+1)'(TO_SLACK);
    localparam logic [CNT_BIT:0]   ONE_W   = (CNT_BIT+1)'(1);

    state_t             state_q,  state_d;
    logic               err_q,    err_d;
    logic [CNT_BIT-1:0] count_q,  count_d;
    logic [CNT_BIT:0]   wcnt_q,   wcnt_d;
    logic               rvalid_q, rvalid_d;

    logic               host_gnt;
    logic               cnt_legal;
    logic [CNT_BIT:0]   wcnt_inc;
    logic [CNT_BIT:0]   wlimit;

    // A start request wins a same-cycle collision; the host simply retries.
    assign host_gnt  = host.host_req_i & (state_q == S_IDLE) & ~cmd_start_i;
    assign cnt_legal = (cmd_count_i != '0) && (cmd_count_i <= MAX_CNT);
    // Wait counter is one bit wider than the run count so count + slack never wraps.
    assign wcnt_inc  = wcnt_q + ONE_W;
    assign wlimit    = {1'b0, count_q} + SLACK_W;

    // State and datapath registers; reset aborts any run immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            err_q    <= 1'b0;
            count_q  <= '0;
            wcnt_q   <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wcnt_q   <= wcnt_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic: launch on legal start, wait for done or timeout.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        count_d  = count_q;
        wcnt_d   = wcnt_q;
        // BRAM0 has one cycle of read latency behind a granted host read.
        rvalid_d = host_gnt & ~host.host_we_i;
        case (state_q)
            S_IDLE: begin
                if (cmd_start_i) begin
                    if (cnt_legal) begin
                        state_d = S_LAUNCH;
                        count_d = cmd_count_i;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (acc_done_i) begin
                    state_d = S_DONE;
                end else begin
                    wcnt_d = wcnt_inc;
                    if (wcnt_inc == wlimit) begin
                        state_d = S_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: status decode and BRAM0 port mux (accessor owns it in LAUNCH/WAIT).
    always_comb begin
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        acc_start_o = (state_q == S_LAUNCH);
        if ((state_q == S_LAUNCH) || (state_q == S_WAIT)) begin
            bram_addr_o = acc_addr_i;
            bram_ce_o   = acc_ce_i;
            bram_we_o   = 1'b0;
            bram_d_o    = '0;
        end else begin
            bram_addr_o = host.host_addr_i;
            bram_ce_o   = host_gnt;
            bram_we_o   = host_gnt & host.host_we_i;
            bram_d_o    = host.host_wdata_i;
        end
    end

    assign err_o              = err_q;
    assign acc_count_o        = count_q;
    assign host.host_gnt_o    = host_gnt;
    assign host.host_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_bram_run_scheduler.sv
// Directed bench for bram_run_scheduler: a per-cycle vector table for the
// host preload, normal runs, illegal counts and ignored events, followed by
// hand-written sequences for the timeout and the start/host collision with a
// mid-run reset.
module tb_bram_run_scheduler;

    localparam int CNT_BIT = 31;
    localparam int AWIDTH  = 8;
    localparam int DWIDTH  = 32;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               cmd_start = 1'b0;
    logic [CNT_BIT-1:0] cmd_count = '0;
    logic               busy, done, err, acc_start;
    logic [CNT_BIT-1:0] acc_count;
    logic               acc_done = 1'b0;
    logic [AWIDTH-1:0]  acc_addr = '0;
    logic               acc_ce = 1'b0;
    logic [AWIDTH-1:0]  bram_addr;
    logic               bram_ce, bram_we;
    logic [DWIDTH-1:0]  bram_d;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_run_scheduler_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) hif ();

    bram_run_scheduler #(
        .CNT_BIT(CNT_BIT), .AWIDTH(AWIDTH), .DWIDTH(DWIDTH),
        .MEM_SIZE(256), .TO_SLACK(16)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start_i(cmd_start), .cmd_count_i(cmd_count),
        .busy_o(busy), .done_o(done), .err_o(err),
        .host(hif),
        .acc_start_o(acc_start), .acc_count_o(acc_count),
        .acc_done_i(acc_done), .acc_addr_i(acc_addr), .acc_ce_i(acc_ce),
        .bram_addr_o(bram_addr), .bram_ce_o(bram_ce),
        .bram_we_o(bram_we), .bram_d_o(bram_d)
    );

    typedef struct {
        string nm;
        bit    req, we;  int addr, wdata;
        bit    st;       int cnt;
        bit    adone, ace; int aaddr;
        bit    gnt, rv, busy, done, err, ast, ce, bwe;
        int    baddr, bd, ecnt;
    } vec_t;

    vec_t vq[$];

    function automatic void add(string nm,
        bit req, bit we, int addr, int wdata, bit st, int cnt,
        bit adone, bit ace, int aaddr,
        bit gnt, bit rv, bit bsy, bit dn, bit er, bit ast,
        bit ce, bit bwe, int baddr, int bd, int ecnt);
        vec_t v;
        v.nm = nm; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
        v.st = st; v.cnt = cnt; v.adone = adone; v.ace = ace; v.aaddr = aaddr;
        v.gnt = gnt; v.rv = rv; v.busy = bsy; v.done = dn; v.err = er;
        v.ast = ast; v.ce = ce; v.bwe = bwe; v.baddr = baddr; v.bd = bd;
        v.ecnt = ecnt;
        vq.push_back(v);
    endfunction

    function automatic logic [78:0] observed();
        return {hif.host_gnt_o, hif.host_rvalid_o, busy, done, err, acc_start,
                bram_ce, bram_we, bram_addr, bram_d, acc_count};
    endfunction

    function automatic logic [78:0] expected(vec_t v);
        return {v.gnt, v.rv, v.busy, v.done, v.err, v.ast, v.ce, v.bwe,
                AWIDTH'(v.baddr), DWIDTH'(v.bd), CNT_BIT'(v.ecnt)};
    endfunction

    task automatic check(string nm, logic [78:0] act, logic [78:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        hif.host_req_i   = v.req;
        hif.host_we_i    = v.we;
        hif.host_addr_i  = AWIDTH'(v.addr);
        hif.host_wdata_i = DWIDTH'(v.wdata);
        cmd_start        = v.st;
        cmd_count        = CNT_BIT'(v.cnt);
        acc_done         = v.adone;
        acc_ce           = v.ace;
        acc_addr         = AWIDTH'(v.aaddr);
    endtask

    task automatic idle_inputs();
        hif.host_req_i = 1'b0; hif.host_we_i = 1'b0;
        hif.host_addr_i = '0;  hif.host_wdata_i = '0;
        cmd_start = 1'b0; cmd_count = '0;
        acc_done = 1'b0; acc_ce = 1'b0; acc_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        idle_inputs();

        // Columns: name | req we addr wdata | start count | adone ace aaddr |
        //          gnt rv busy done err ast | ce we baddr bd | acc_count
        add("idle_after_reset",  0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          0);
        add("host_wr0",          1,1,0,'h11,    0,0,   0,0,0, 1,0,0,0,0,0, 1,1,0,'h11,       0);
        add("host_wr1",          1,1,1,'h22,    0,0,   0,0,0, 1,0,0,0,0,0, 1,1,1,'h22,       0);
        add("host_wr2",          1,1,2,'h33,    0,0,   0,0,0, 1,0,0,0,0,0, 1,1,2,'h33,       0);
        add("host_wr3",          1,1,3,'h44,    0,0,   0,0,0, 1,0,0,0,0,0, 1,1,3,'h44,       0);
        add("host_rd2",          1,0,2,0,       0,0,   0,0,0, 1,0,0,0,0,0, 1,0,2,0,          0);
        add("host_rd2_rvalid",   0,0,0,0,       0,0,   0,0,0, 0,1,0,0,0,0, 0,0,0,0,          0);
        add("idle_a",            0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          0);
        add("start_cnt4",        0,0,0,0,       1,4,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          0);
        add("launch_cnt4",       0,0,0,0,       0,0,   0,0,0, 0,0,1,0,0,1, 0,0,0,0,          4);
        add("wait_hreq_a0",      1,1,5,'h55,    0,0,   0,1,0, 0,0,1,0,0,0, 1,0,0,0,          4);
        add("wait_hreq_a1",      1,1,5,'h55,    0,0,   0,1,1, 0,0,1,0,0,0, 1,0,1,0,          4);
        add("wait_hreq_a2",      1,1,5,'h55,    0,0,   0,1,2, 0,0,1,0,0,0, 1,0,2,0,          4);
        add("wait_hreq_a3",      1,1,5,'h55,    0,0,   0,1,3, 0,0,1,0,0,0, 1,0,3,0,          4);
        add("wait_acc_done",     1,1,5,'h55,    0,0,   1,0,0, 0,0,1,0,0,0, 0,0,0,0,          4);
        add("done_cnt4",         1,1,5,'h55,    0,0,   0,0,0, 0,0,1,1,0,0, 0,0,5,'h55,       4);
        add("gnt_resumes",       1,1,5,'h55,    0,0,   0,0,0, 1,0,0,0,0,0, 1,1,5,'h55,       4);
        add("idle_b",            0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          4);
        add("start_cnt0",        0,0,0,0,       1,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          4);
        add("err_after_cnt0",    0,0,0,0,       0,0,   0,0,0, 0,0,0,0,1,0, 0,0,0,0,          4);
        add("start_cnt257",      0,0,0,0,       1,257, 0,0,0, 0,0,0,0,1,0, 0,0,0,0,          4);
        add("err_after_cnt257",  0,0,0,0,       0,0,   0,0,0, 0,0,0,0,1,0, 0,0,0,0,          4);
        add("start_cnt3",        0,0,0,0,       1,3,   0,0,0, 0,0,0,0,1,0, 0,0,0,0,          4);
        add("launch_cnt3_clr",   0,0,0,0,       0,0,   0,0,0, 0,0,1,0,0,1, 0,0,0,0,          3);
        add("wait_cnt3_done",    0,0,0,0,       0,0,   1,0,0, 0,0,1,0,0,0, 0,0,0,0,          3);
        add("done_cnt3",         0,0,0,0,       0,0,   0,0,0, 0,0,1,1,0,0, 0,0,0,0,          3);
        add("idle_stray_done",   0,0,0,0,       0,0,   1,0,0, 0,0,0,0,0,0, 0,0,0,0,          3);
        add("idle_c",            0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          3);
        add("start_cnt256",      0,0,0,0,       1,256, 0,0,0, 0,0,0,0,0,0, 0,0,0,0,          3);
        add("launch_cnt256",     0,0,0,0,       0,0,   0,0,0, 0,0,1,0,0,1, 0,0,0,0,        256);
        add("wait_busy_start",   0,0,0,0,       1,5,   1,0,0, 0,0,1,0,0,0, 0,0,0,0,        256);
        add("done_cnt256",       0,0,0,0,       0,0,   0,0,0, 0,0,1,1,0,0, 0,0,0,0,        256);
        add("idle_d",            0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,        256);
        add("host_rd1",          1,0,1,0,       0,0,   0,0,0, 1,0,0,0,0,0, 1,0,1,0,        256);
        add("rd_then_start",     0,0,0,0,       1,1,   0,0,0, 0,1,0,0,0,0, 0,0,0,0,        256);
        add("launch_cnt1",       0,0,0,0,       0,0,   0,0,0, 0,0,1,0,0,1, 0,0,0,0,          1);
        add("wait_cnt1_done",    0,0,0,0,       0,0,   1,0,0, 0,0,1,0,0,0, 0,0,0,0,          1);
        add("done_cnt1",         0,0,0,0,       0,0,   0,0,0, 0,0,1,1,0,0, 0,0,0,0,          1);
        add("idle_e",            0,0,0,0,       0,0,   0,0,0, 0,0,0,0,0,0, 0,0,0,0,          1);

        // Reset asserted: every status/control output is low.
        step();
        check("in_reset", observed() & ~79'(DWIDTH'('1) << CNT_BIT), 79'(0));
        step();
        reset_n = 1'b1;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #2;
            check(vq[i].nm, observed(), expected(vq[i]));
            step();
        end
        idle_inputs();

        // Timeout: count 2, accessor never answers -> 18 WAIT cycles, then DONE with err.
        cmd_start = 1'b1; cmd_count = CNT_BIT'(2);
        step();
        cmd_start = 1'b0; cmd_count = '0;
        check("to_launch", 79'({acc_start, busy, acc_count}), 79'({1'b1, 1'b1, CNT_BIT'(2)}));
        step();
        n = 0;
        while (!done && n < 100) begin
            n++;
            step();
        end
        check("to_wait_cycles", 79'(n), 79'(18));
        check("to_done_err", 79'({done, err, busy}), 79'(3'b111));
        step();
        check("to_back_idle", 79'({busy, done, err}), 79'(3'b001));

        // Start and host request in the same IDLE cycle: start wins.
        cmd_start = 1'b1; cmd_count = CNT_BIT'(5);
        hif.host_req_i = 1'b1; hif.host_we_i = 1'b0; hif.host_addr_i = 8'h07;
        #2;
        check("collide_gnt", 79'({hif.host_gnt_o, bram_ce}), 79'(2'b00));
        step();
        idle_inputs();
        check("collide_launch", 79'({acc_start, busy, err, hif.host_rvalid_o}), 79'(4'b1100));
        step();
        step();
        check("mid_wait_busy", 79'({busy, acc_start, done}), 79'(3'b100));

        // Asynchronous reset in WAIT: outputs drop immediately, no done pulse.
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset", 79'({busy, done, err, acc_start, hif.host_gnt_o,
                                  hif.host_rvalid_o, acc_count}), 79'(0));
        n = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            if (done) n++;
        end
        check("no_done_in_reset", 79'(n), 79'(0));
        reset_n = 1'b1;
        #2;
        check("post_reset_idle", 79'({busy, done, err, acc_start}), 79'(0));
        hif.host_req_i = 1'b1; hif.host_we_i = 1'b1;
        hif.host_addr_i = 8'h09; hif.host_wdata_i = 32'hA5A5_0001;
        #1;
        check("post_reset_gnt", 79'({hif.host_gnt_o, bram_we, bram_addr, bram_d}),
              79'({1'b1, 1'b1, 8'h09, 32'hA5A5_0001}));
        step();
        idle_inputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
